// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller.
package if_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StDrop,
    StHold,
    StErr
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_ctrl_if.sv
// Instruction-memory request/acknowledge handshake between fetch and memory.
interface if_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_ctrl.sv
// Fetch-stage controller: owns the fetch PC, drives the instruction-memory
// handshake and fills the IF/ID register, with a one-entry skid buffer for
// decode stalls and a watchdog for a memory that never acknowledges.
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        br_taken,
  input  logic [31:0] ex_add,
  if_ctrl_if.master   imem,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_dc,
  output logic        if_valid,
  output logic        flush_id,
  output logic        fetch_err
);

  // Timeout fires on the cycle the counter would reach MAX_WAIT.
  localparam logic [7:0] WaitLimit = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        err_q, err_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_insn_q, skid_insn_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic in_req;
  logic slot_free;
  logic timeout;

  assign in_req    = (state_q == StWait) || (state_q == StDrop);
  assign slot_free = !valid_q || !hazard;
  assign timeout   = in_req && !imem.imem_ack && (wait_cnt_q >= WaitLimit);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: fetch PC, IF/ID slot, skid entry, watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      insn_q       <= NOP_INSN;
      pc_q         <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      err_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_insn_q  <= '0;
      skid_pc_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      drop_addr_q  <= drop_addr_d;
      insn_q       <= insn_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
      err_q        <= err_d;
      skid_valid_q <= skid_valid_d;
      skid_insn_q  <= skid_insn_d;
      skid_pc_q    <= skid_pc_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Next state and datapath updates; order encodes ERR lock > timeout > redirect > ack/hazard.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_addr_d  = drop_addr_q;
    insn_d       = insn_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    flush_d      = 1'b0;
    err_d        = err_q;
    skid_valid_d = skid_valid_q;
    skid_insn_d  = skid_insn_q;
    skid_pc_d    = skid_pc_q;
    wait_cnt_d   = (in_req && !imem.imem_ack) ? wait_cnt_q + 8'd1 : 8'd0;

    if (state_q == StErr) begin
      valid_d = 1'b0;
    end else if (timeout) begin
      state_d      = StErr;
      err_d        = 1'b1;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (br_taken) begin
      flush_d      = 1'b1;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      fetch_pc_d   = word_align(ex_add);
      if (in_req && !imem.imem_ack) begin
        // The outstanding request must complete on its original address.
        state_d = StDrop;
        if (state_q == StWait) begin
          drop_addr_d = fetch_pc_q;
        end
      end else begin
        state_d = StWait;
      end
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StWait;
        end
        StWait: begin
          if (imem.imem_ack) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (slot_free) begin
              insn_d  = imem.imem_rdata;
              pc_d    = fetch_pc_q;
              pc4_d   = fetch_pc_q + PC_STEP;
              valid_d = 1'b1;
            end else begin
              skid_valid_d = 1'b1;
              skid_insn_d  = imem.imem_rdata;
              skid_pc_d    = fetch_pc_q;
              state_d      = StHold;
            end
          end else if (valid_q && !hazard) begin
            valid_d = 1'b0;
          end
        end
        StDrop: begin
          if (imem.imem_ack) begin
            state_d = StWait;
          end
        end
        StHold: begin
          if (!hazard) begin
            insn_d       = skid_insn_q;
            pc_d         = skid_pc_q;
            pc4_d        = skid_pc_q + PC_STEP;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
            state_d      = StWait;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Outputs: handshake decoded from state, IF/ID straight from registers.
  always_comb begin
    imem.imem_req  = in_req;
    imem.imem_addr = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;
    instruction    = insn_q;
    pc_out         = pc_q;
    pc4_dc         = pc4_q;
    if_valid       = valid_q;
    flush_id       = flush_q;
    fetch_err      = err_q;
  end

endmodule

// File: tb/tb_if_ctrl.sv
// Self-checking bench for if_ctrl: directed scenarios plus a randomized run
// scored against a fetch-stream model (expected PC sequence per delivery).
module tb_if_ctrl;
  import if_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] ex_add = '0;
  logic [31:0] instruction, pc_out, pc4_dc;
  logic        if_valid, flush_id, fetch_err;

  if_ctrl_if ifc ();

  if_ctrl #(
    .RESET_PC(RESET_PC),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hazard     (hazard),
    .br_taken   (br_taken),
    .ex_add     (ex_add),
    .imem       (ifc),
    .instruction(instruction),
    .pc_out     (pc_out),
    .pc4_dc     (pc4_dc),
    .if_valid   (if_valid),
    .flush_id   (flush_id),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state.
  int mem_wait = 0;
  int cur_lat  = 0;
  int lat_max  = 0;
  bit lat_rand = 1'b0;
  bit last_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic int next_lat();
    return lat_rand ? int'($urandom_range(lat_max, 0)) : lat_max;
  endfunction

  // One clock: memory answers the current request, then sample 1 time unit after the edge.
  task automatic tick();
    bit req_now, ack_now;
    req_now = (ifc.imem_req === 1'b1);
    ack_now = req_now && (mem_wait >= cur_lat);
    ifc.imem_ack   = ack_now;
    ifc.imem_rdata = ack_now ? mem_word(ifc.imem_addr) : $urandom;
    @(posedge clk);
    #1;
    last_ack = ack_now;
    if (ack_now) begin
      mem_wait = 0;
      cur_lat  = next_lat();
    end else if (req_now) begin
      mem_wait++;
    end else begin
      mem_wait = 0;
    end
  endtask

  // Leaves rst deasserted with the DUT sitting in its reset state.
  task automatic reset_dut();
    rst      = 1'b1;
    hazard   = 1'b0;
    br_taken = 1'b0;
    ex_add   = '0;
    tick();
    tick();
    mem_wait = 0;
    cur_lat  = next_lat();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    lat_rand = 1'b0;
    lat_max  = 0;
    reset_dut();
    n_checks++;
    if ({ifc.imem_req, if_valid, flush_id, fetch_err} !== 4'b0000 || ifc.imem_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL reset_ctl: req/valid/flush/err=%b addr=%h, want 0000 addr=%h",
               {ifc.imem_req, if_valid, flush_id, fetch_err}, ifc.imem_addr, RESET_PC);
    end
    n_checks++;
    if ({instruction, pc_out, pc4_dc} !== {NOP_INSN, 64'h0}) begin
      n_errors++;
      $display("FAIL reset_ifid: insn=%h pc=%h pc4=%h, want %h 0 0",
               instruction, pc_out, pc4_dc, NOP_INSN);
    end
    tick();
    n_checks++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL first_req: req=%b addr=%h, want 1 %h", ifc.imem_req, ifc.imem_addr, RESET_PC);
    end
    // Abandon a pending request with reset.
    cur_lat = 1000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({ifc.imem_req, if_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL rst_mid_req: req/valid=%b, want 00", {ifc.imem_req, if_valid});
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    lat_rand = 1'b0;
    lat_max  = 0;
    reset_dut();
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'(4 * k)) begin
        n_errors++;
        $display("FAIL stream_addr[%0d]: req=%b addr=%h, want 1 %h", k, ifc.imem_req,
                 ifc.imem_addr, 32'(4 * k));
      end
      if (k > 0) begin
        n_checks++;
        if (if_valid !== 1'b1 || pc_out !== 32'(4 * (k - 1)) || pc4_dc !== 32'(4 * k) ||
            instruction !== mem_word(32'(4 * (k - 1)))) begin
          n_errors++;
          $display("FAIL stream_ifid[%0d]: v=%b pc=%h pc4=%h insn=%h, want 1 %h %h %h", k,
                   if_valid, pc_out, pc4_dc, instruction, 32'(4 * (k - 1)), 32'(4 * k),
                   mem_word(32'(4 * (k - 1))));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    lat_rand = 1'b0;
    lat_max  = 0;
    reset_dut();
    tick();
    tick();
    tick();
    hazard = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (if_valid !== 1'b1 || pc_out !== 32'h4 || instruction !== mem_word(32'h4) ||
          ifc.imem_req !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h req=%b, want 1 00000004 0", k, if_valid,
                 pc_out, ifc.imem_req);
      end
    end
    hazard = 1'b0;
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || pc_out !== 32'h8 || pc4_dc !== 32'hC ||
        instruction !== mem_word(32'h8) || ifc.imem_addr !== 32'hC) begin
      n_errors++;
      $display("FAIL stall_release: v=%b pc=%h pc4=%h addr=%h, want 1 8 c c", if_valid, pc_out,
               pc4_dc, ifc.imem_addr);
    end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || pc_out !== 32'hC) begin
      n_errors++;
      $display("FAIL stall_next: v=%b pc=%h, want 1 0000000c", if_valid, pc_out);
    end
  endtask

  task automatic test_redirect();
    lat_rand = 1'b0;
    lat_max  = 0;
    reset_dut();
    for (int k = 0; k < 4; k++) tick();
    // Hazard in the same cycle must be ignored.
    br_taken = 1'b1;
    ex_add   = 32'h0000_0103;
    hazard   = 1'b1;
    tick();
    br_taken = 1'b0;
    hazard   = 1'b0;
    n_checks++;
    if ({flush_id, if_valid, ifc.imem_req} !== 3'b101 || ifc.imem_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL redirect_flush: flush/valid/req=%b addr=%h, want 101 00000100",
               {flush_id, if_valid, ifc.imem_req}, ifc.imem_addr);
    end
    tick();
    n_checks++;
    if (flush_id !== 1'b0 || if_valid !== 1'b1 || pc_out !== 32'h100 || pc4_dc !== 32'h104 ||
        instruction !== mem_word(32'h100)) begin
      n_errors++;
      $display("FAIL redirect_first: flush=%b v=%b pc=%h pc4=%h, want 0 1 100 104", flush_id,
               if_valid, pc_out, pc4_dc);
    end
  endtask

  task automatic test_drop();
    bit seen;
    lat_rand = 1'b0;
    lat_max  = 3;
    reset_dut();
    tick();
    br_taken = 1'b1;
    ex_add   = 32'h0000_0100;
    tick();
    br_taken = 1'b0;
    n_checks++;
    if (flush_id !== 1'b1 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL drop_flush: flush=%b req=%b addr=%h, want 1 1 %h", flush_id, ifc.imem_req,
               ifc.imem_addr, RESET_PC);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (ifc.imem_addr !== RESET_PC || if_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL drop_hold[%0d]: addr=%h v=%b, want %h 0", k, ifc.imem_addr, if_valid,
                 RESET_PC);
      end
    end
    tick();
    n_checks++;
    if (ifc.imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_newaddr: addr=%h v=%b, want 00000100 0", ifc.imem_addr, if_valid);
    end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (if_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || pc_out !== 32'h100 || instruction !== mem_word(32'h100)) begin
      n_errors++;
      $display("FAIL drop_first: seen=%b pc=%h, want 1 00000100", seen, pc_out);
    end
  endtask

  task automatic test_watchdog();
    lat_rand = 1'b0;
    lat_max  = 1000;
    reset_dut();
    tick();
    for (int k = 1; k <= int'(MAX_WAIT); k++) begin
      n_checks++;
      if (fetch_err !== 1'b0 || ifc.imem_req !== 1'b1) begin
        n_errors++;
        $display("FAIL wdog_early[%0d]: err=%b req=%b, want 0 1", k, fetch_err, ifc.imem_req);
      end
      tick();
    end
    n_checks++;
    if ({fetch_err, ifc.imem_req, if_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL wdog_err: err/req/valid=%b, want 100", {fetch_err, ifc.imem_req, if_valid});
    end
    br_taken = 1'b1;
    ex_add   = 32'h40;
    for (int k = 0; k < 3; k++) begin
      hazard = k[0];
      tick();
      n_checks++;
      if ({fetch_err, ifc.imem_req, if_valid, flush_id} !== 4'b1000) begin
        n_errors++;
        $display("FAIL wdog_lock[%0d]: err/req/valid/flush=%b, want 1000", k,
                 {fetch_err, ifc.imem_req, if_valid, flush_id});
      end
    end
    br_taken = 1'b0;
    hazard   = 1'b0;
    lat_max  = 0;
    reset_dut();
    n_checks++;
    if (fetch_err !== 1'b0) begin
      n_errors++;
      $display("FAIL wdog_clear: err=%b, want 0", fetch_err);
    end
  endtask

  task automatic test_wrap();
    lat_rand = 1'b0;
    lat_max  = 0;
    reset_dut();
    tick();
    br_taken = 1'b1;
    ex_add   = 32'hFFFF_FFFF;
    tick();
    br_taken = 1'b0;
    n_checks++;
    if (ifc.imem_addr !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_addr: addr=%h, want fffffffc", ifc.imem_addr);
    end
    tick();
    n_checks++;
    if (pc_out !== 32'hFFFF_FFFC || pc4_dc !== 32'h0 || ifc.imem_addr !== 32'h0 ||
        if_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_ifid: pc=%h pc4=%h addr=%h v=%b, want fffffffc 0 0 1", pc_out, pc4_dc,
               ifc.imem_addr, if_valid);
    end
  endtask

  // Random stalls, redirects and memory latency scored against the expected fetch stream.
  task automatic test_random();
    logic [31:0] exp_pc, p_ex, p_pc, p_insn, p_addr;
    bit p_haz, p_br, p_valid, p_req;
    int delivered;
    lat_rand  = 1'b1;
    lat_max   = 3;
    reset_dut();
    tick();
    exp_pc    = RESET_PC;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      hazard   = ($urandom_range(9, 0) < 3);
      br_taken = ($urandom_range(29, 0) == 0);
      ex_add   = $urandom;
      p_haz    = hazard;
      p_br     = br_taken;
      p_ex     = ex_add;
      p_valid  = if_valid;
      p_pc     = pc_out;
      p_insn   = instruction;
      p_req    = ifc.imem_req;
      p_addr   = ifc.imem_addr;
      tick();
      n_checks++;
      if ({flush_id, fetch_err} !== {p_br, 1'b0}) begin
        n_errors++;
        $display("FAIL rnd_flush[%0d]: flush/err=%b, want %b0", c, {flush_id, fetch_err}, p_br);
      end
      if (p_br) begin
        n_checks++;
        if (if_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL rnd_squash[%0d]: v=%b, want 0", c, if_valid);
        end
        exp_pc = p_ex & ~32'h3;
      end else if (p_valid && p_haz) begin
        n_checks++;
        if (if_valid !== 1'b1 || pc_out !== p_pc || instruction !== p_insn) begin
          n_errors++;
          $display("FAIL rnd_frozen[%0d]: v=%b pc=%h, want 1 %h", c, if_valid, pc_out, p_pc);
        end
      end else if (if_valid === 1'b1) begin
        n_checks++;
        if (pc_out !== exp_pc || pc4_dc !== exp_pc + 32'd4 || instruction !== mem_word(exp_pc))
        begin
          n_errors++;
          $display("FAIL rnd_deliver[%0d]: pc=%h pc4=%h insn=%h, want %h %h %h", c, pc_out,
                   pc4_dc, instruction, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (p_req && !last_ack) begin
        n_checks++;
        if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== p_addr) begin
          n_errors++;
          $display("FAIL rnd_addr_stable[%0d]: req=%b addr=%h, want 1 %h", c, ifc.imem_req,
                   ifc.imem_addr, p_addr);
        end
      end
    end
    hazard   = 1'b0;
    br_taken = 1'b0;
    n_checks++;
    if (delivered < 300) begin
      n_errors++;
      $display("FAIL rnd_progress: delivered=%0d, want >= 300", delivered);
    end
  endtask

  initial begin
    ifc.imem_ack   = 1'b0;
    ifc.imem_rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_drop();
    test_watchdog();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
